// File: rtl/fixed_pe_load_sequencer_pkg.sv
// Shared types and constants for the fixed PE load sequencer.
package fixed_pe_load_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DUMMY,
    ST_WORDS,
    ST_GAP,
    ST_PLACE,
    ST_HOLD
  } state_e;

  // Zero words between the phase-start cycle and the first sum word; the
  // shared counter reaches this value on the last dummy cycle of a phase.
  localparam int DUMMY_WORDS  = 7;
  // Header words driven in the X phase (swap_cycles, swap_sets).
  localparam int HEADER_WORDS = 2;
  // X sums occupy the bottom half of the sum table.
  localparam int X_BASE       = 0;

  // Y sums follow the N X sums.
  function automatic int y_base(input int n);
    return n;
  endfunction

endpackage

// File: rtl/fixed_pe_load_sequencer.sv
// Drives the fixed PE load bus for one host command: X header/sums, Y sums,
// then a place pulse, fetching sums from a 1-cycle-latency table.
module fixed_pe_load_sequencer
  import fixed_pe_load_sequencer_pkg::*;
#(
  parameter int N          = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 32,
  parameter int PHASE_GAP  = 1,
  parameter int ADDR_WIDTH = $clog2(2 * N),
  parameter int HOLD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [BUS_WIDTH-1:0]  cmd_swap_cycles,
  input  logic [BUS_WIDTH-1:0]  cmd_swap_sets,
  input  logic [HOLD_WIDTH-1:0] cmd_hold_cycles,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  load_enable_out,
  output logic [BUS_WIDTH-1:0]  load_out,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_MAX_A = (N > DUMMY_WORDS) ? N : DUMMY_WORDS;
  localparam int CNT_MAX   = (CNT_MAX_A > PHASE_GAP) ? CNT_MAX_A : PHASE_GAP;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int GAP_LAST  = (PHASE_GAP > 0) ? PHASE_GAP - 1 : 0;

  localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_HDR_LAST_X = CNT_W'(HEADER_WORDS - 1);
  localparam logic [CNT_W-1:0] C_DUMMY_LAST = CNT_W'(DUMMY_WORDS);
  localparam logic [CNT_W-1:0] C_WORD_LAST  = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] C_GAP_LAST   = CNT_W'(GAP_LAST);
  // A word must be requested two cycles before its bus slot (RAM latency
  // plus the output register), so the first read falls on dummy slot 6.
  localparam logic [CNT_W-1:0] C_RD_FIRST   = CNT_W'(DUMMY_WORDS - 1);

  localparam logic [ADDR_WIDTH-1:0] A_X   = ADDR_WIDTH'(X_BASE);
  localparam logic [ADDR_WIDTH-1:0] A_Y   = ADDR_WIDTH'(y_base(N));
  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);
  localparam logic [HOLD_WIDTH-1:0] H_ONE = HOLD_WIDTH'(1);

  state_e                r_state, w_state_nx;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nx;
  logic                  r_phase_y, w_phase_y_nx;
  logic [HOLD_WIDTH-1:0] r_hcnt, w_hcnt_nx;
  logic [ADDR_WIDTH-1:0] r_rd_idx, w_rd_idx_nx;

  logic [BUS_WIDTH-1:0]  r_swap_cycles, r_swap_sets;
  logic [HOLD_WIDTH-1:0] r_hold;

  logic                  r_ready, r_busy, r_en, r_done, r_rd_en;
  logic [ADDR_WIDTH-1:0] r_rd_addr, w_rd_addr_nx;
  logic [BUS_WIDTH-1:0]  r_load, w_load_nx;
  logic                  w_accept, w_en_nx, w_rd_en_nx;

  assign w_accept = cmd_valid & r_ready;

  // Next-state logic: shared counter tracks position inside HDR/DUMMY/WORDS/GAP.
  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_phase_y_nx = r_phase_y;
    w_hcnt_nx    = r_hcnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nx   = ST_HDR;
          w_cnt_nx     = '0;
          w_phase_y_nx = 1'b0;
        end
      end
      ST_HDR: begin
        // Y has only the enable cycle; X stays here for both header words.
        w_cnt_nx = r_cnt + C_ONE;
        if (r_phase_y || r_cnt == C_HDR_LAST_X) w_state_nx = ST_DUMMY;
      end
      ST_DUMMY: begin
        if (r_cnt == C_DUMMY_LAST) begin
          w_state_nx = ST_WORDS;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + C_ONE;
        end
      end
      ST_WORDS: begin
        if (r_cnt != C_WORD_LAST) begin
          w_cnt_nx = r_cnt + C_ONE;
        end else if (PHASE_GAP > 0) begin
          w_state_nx = ST_GAP;
          w_cnt_nx   = '0;
        end else if (!r_phase_y) begin
          w_state_nx   = ST_HDR;
          w_cnt_nx     = '0;
          w_phase_y_nx = 1'b1;
        end else begin
          w_state_nx = ST_PLACE;
        end
      end
      ST_GAP: begin
        if (r_cnt != C_GAP_LAST) begin
          w_cnt_nx = r_cnt + C_ONE;
        end else if (!r_phase_y) begin
          w_state_nx   = ST_HDR;
          w_cnt_nx     = '0;
          w_phase_y_nx = 1'b1;
        end else begin
          w_state_nx = ST_PLACE;
        end
      end
      ST_PLACE: begin
        w_hcnt_nx  = H_ONE;
        w_state_nx = (r_hold == '0) ? ST_IDLE : ST_HOLD;
      end
      ST_HOLD: begin
        if (r_hcnt == r_hold) w_state_nx = ST_IDLE;
        else                  w_hcnt_nx  = r_hcnt + H_ONE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Output decode from the next state so every output leaves a register.
  always_comb begin
    w_en_nx    = (w_state_nx == ST_HDR && w_cnt_nx == '0) || (w_state_nx == ST_PLACE);
    w_rd_en_nx = ((w_state_nx == ST_DUMMY) && (w_cnt_nx >= C_RD_FIRST) &&
                  (int'(w_cnt_nx) - (DUMMY_WORDS - 1) < N)) ||
                 ((w_state_nx == ST_WORDS) && (int'(w_cnt_nx) + 2 < N));
    w_rd_addr_nx = '0;
    w_rd_idx_nx  = r_rd_idx;
    if (w_state_nx == ST_HDR) begin
      w_rd_idx_nx = '0;
    end else if (w_rd_en_nx) begin
      w_rd_addr_nx = (w_phase_y_nx ? A_Y : A_X) + r_rd_idx;
      w_rd_idx_nx  = r_rd_idx + A_ONE;
    end
    w_load_nx = '0;
    if (w_accept)
      w_load_nx = cmd_swap_cycles;
    else if (w_state_nx == ST_HDR && !w_phase_y_nx && w_cnt_nx == C_HDR_LAST_X)
      w_load_nx = r_swap_sets;
    else if (w_state_nx == ST_WORDS)
      w_load_nx = BUS_WIDTH'(mem_rd_data);
  end

  // Control and output registers; reset aborts any sequence in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_phase_y <= 1'b0;
      r_hcnt    <= '0;
      r_rd_idx  <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_en      <= 1'b0;
      r_done    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_load    <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_phase_y <= w_phase_y_nx;
      r_hcnt    <= w_hcnt_nx;
      r_rd_idx  <= w_rd_idx_nx;
      r_ready   <= (w_state_nx == ST_IDLE);
      r_busy    <= (w_state_nx != ST_IDLE);
      r_en      <= w_en_nx;
      r_done    <= (w_state_nx == ST_PLACE);
      r_rd_en   <= w_rd_en_nx;
      r_rd_addr <= w_rd_addr_nx;
      r_load    <= w_load_nx;
    end
  end

  // Command fields are captured once on accept and held for the whole sequence.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_swap_cycles <= cmd_swap_cycles;
      r_swap_sets   <= cmd_swap_sets;
      r_hold        <= cmd_hold_cycles;
    end
  end

  assign cmd_ready       = r_ready;
  assign busy            = r_busy;
  assign load_enable_out = r_en;
  assign done            = r_done;
  assign mem_rd_en       = r_rd_en;
  assign mem_rd_addr     = r_rd_addr;
  assign load_out        = r_load;

  // r_swap_cycles is captured for completeness of the latched command; the
  // header slot is driven directly from the port on the accept cycle.
  logic w_unused;
  assign w_unused = ^r_swap_cycles;

endmodule

// File: tb/tb_fixed_pe_load_sequencer.sv
// Bench for fixed_pe_load_sequencer: two instances (PHASE_GAP=1 with 32-bit
// sums, PHASE_GAP=0 with 16-bit sums) against a slot-timeline model.
module tb_fixed_pe_load_sequencer;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid1 = 1'b0, cmd_valid0 = 1'b0;
  logic [31:0] cmd_swap_cycles = '0, cmd_swap_sets = '0;
  logic [15:0] cmd_hold_cycles = '0;

  logic        ready1, rd_en1, en1, busy1, done1;
  logic [2:0]  rd_addr1;
  logic [31:0] rdata1, load1;
  logic        ready0, rd_en0, en0, busy0, done0;
  logic [2:0]  rd_addr0;
  logic [15:0] rdata0;
  logic [31:0] load0;

  logic [31:0] mem1 [0:7];
  logic [15:0] mem0 [0:7];
  int q1[$], q0[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fixed_pe_load_sequencer #(.N(N), .DATA_WIDTH(32), .BUS_WIDTH(32), .PHASE_GAP(1), .HOLD_WIDTH(16)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_ready(ready1),
    .cmd_swap_cycles(cmd_swap_cycles), .cmd_swap_sets(cmd_swap_sets), .cmd_hold_cycles(cmd_hold_cycles),
    .mem_rd_en(rd_en1), .mem_rd_addr(rd_addr1), .mem_rd_data(rdata1),
    .load_enable_out(en1), .load_out(load1), .busy(busy1), .done(done1));

  fixed_pe_load_sequencer #(.N(N), .DATA_WIDTH(16), .BUS_WIDTH(32), .PHASE_GAP(0), .HOLD_WIDTH(16)) u_dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid0), .cmd_ready(ready0),
    .cmd_swap_cycles(cmd_swap_cycles), .cmd_swap_sets(cmd_swap_sets), .cmd_hold_cycles(cmd_hold_cycles),
    .mem_rd_en(rd_en0), .mem_rd_addr(rd_addr0), .mem_rd_data(rdata0),
    .load_enable_out(en0), .load_out(load0), .busy(busy0), .done(done0));

  // Sum tables with 1-cycle read latency; garbage when no read was issued.
  always @(posedge clk) begin
    if (rd_en1) q1.push_back(int'(rd_addr1));
    if (rd_en0) q0.push_back(int'(rd_addr0));
    rdata1 <= rd_en1 ? mem1[rd_addr1] : $urandom;
    rdata0 <= rd_en0 ? mem0[rd_addr0] : 16'($urandom);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] word_of(input int gap, input int idx);
    if (gap == 0) return {16'h0000, mem0[idx]};
    return mem1[idx];
  endfunction

  task automatic sample(input int gap, output logic en, output logic dn, output logic rdy,
                        output logic bsy, output logic rde, output logic [31:0] ld);
    if (gap == 0) begin en = en0; dn = done0; rdy = ready0; bsy = busy0; rde = rd_en0; ld = load0; end
    else          begin en = en1; dn = done1; rdy = ready1; bsy = busy1; rde = rd_en1; ld = load1; end
  endtask

  task automatic set_mem_default();
    for (int k = 0; k < N; k++) begin
      mem1[k] = 32'(11 + k); mem1[N + k] = 32'(21 + k);
      mem0[k] = 16'(11 + k); mem0[N + k] = 16'(21 + k);
    end
  endtask

  // Waits for cmd_ready of the selected instance; returns at #1 after the accept edge (t=0).
  task automatic wait_accept(input int gap, output bit ok);
    logic en, dn, rdy, bsy, rde; logic [31:0] ld;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      sample(gap, en, dn, rdy, bsy, rde, ld);
      if (rdy === 1'b1) begin
        @(posedge clk); #1;
        ok = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL accept_timeout gap=%0d: cmd_ready never rose within 200 cycles", gap);
  endtask

  // Checks slots t=0..min(limit, tP+hold+1); called at #1 into t=0, returns at #1 into the last slot.
  task automatic check_seq(input int gap, input logic [31:0] sc, input logic [31:0] ss,
                           input int hold, input int limit, input string tag);
    int tY, tP, last;
    logic [31:0] exp_ld, ld;
    logic exp_en, exp_dn, exp_rdy, en, dn, rdy, bsy, rde;
    tY = 8 + N + gap;
    tP = tY + 8 + N + gap;
    last = tP + hold + 1;
    if (limit < last) last = limit;
    for (int t = 0; t <= last; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      exp_en  = (t == 0) || (t == tY) || (t == tP);
      exp_dn  = (t == tP);
      exp_rdy = (t > tP + hold);
      exp_ld  = '0;
      if (t == 0) exp_ld = sc;
      else if (t == 1) exp_ld = ss;
      else if (t >= 8 && t < 8 + N) exp_ld = word_of(gap, t - 8);
      else if (t >= tY + 8 && t < tY + 8 + N) exp_ld = word_of(gap, N + t - tY - 8);
      sample(gap, en, dn, rdy, bsy, rde, ld);
      checks++;
      if (en !== exp_en) begin errors++;
        $display("FAIL %s enable t=%0d: got %b expected %b", tag, t, en, exp_en); end
      checks++;
      if (ld !== exp_ld) begin errors++;
        $display("FAIL %s load_out t=%0d: got %h expected %h", tag, t, ld, exp_ld); end
      checks++;
      if (dn !== exp_dn) begin errors++;
        $display("FAIL %s done t=%0d: got %b expected %b", tag, t, dn, exp_dn); end
      checks++;
      if (rdy !== exp_rdy) begin errors++;
        $display("FAIL %s cmd_ready t=%0d: got %b expected %b", tag, t, rdy, exp_rdy); end
      checks++;
      if (bsy !== !exp_rdy) begin errors++;
        $display("FAIL %s busy t=%0d: got %b expected %b", tag, t, bsy, !exp_rdy); end
    end
  endtask

  // Expects exactly 2N reads at addresses 0..2N-1 in order, then clears the log.
  task automatic check_reads(input int gap, input string tag);
    int q[$];
    q = (gap == 0) ? q0 : q1;
    checks++;
    if (q.size() != 2 * N) begin errors++;
      $display("FAIL %s read_count: got %0d expected %0d", tag, q.size(), 2 * N); end
    for (int i = 0; i < q.size() && i < 2 * N; i++) begin
      checks++;
      if (q[i] != i) begin errors++;
        $display("FAIL %s read_addr[%0d]: got %0d expected %0d", tag, i, q[i], i); end
    end
    if (gap == 0) q0.delete(); else q1.delete();
  endtask

  task automatic run_cmd(input int gap, input logic [31:0] sc, input logic [31:0] ss,
                         input int hold, input string tag);
    bit ok;
    cmd_swap_cycles = sc; cmd_swap_sets = ss; cmd_hold_cycles = 16'(hold);
    if (gap == 0) begin q0.delete(); cmd_valid0 = 1'b1; end
    else          begin q1.delete(); cmd_valid1 = 1'b1; end
    wait_accept(gap, ok);
    cmd_valid0 = 1'b0; cmd_valid1 = 1'b0;
    if (ok) begin
      check_seq(gap, sc, ss, hold, 1000, tag);
      check_reads(gap, tag);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy1); end
    checks++; if (en1 !== 1'b0 || done1 !== 1'b0 || rd_en1 !== 1'b0) begin errors++;
      $display("FAIL reset_ctrl: got en=%b done=%b rd_en=%b expected 0", en1, done1, rd_en1); end
    checks++; if (load1 !== 32'h0) begin errors++; $display("FAIL reset_load: got %h expected 0", load1); end
    checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b expected 0", ready0); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (ready1 !== 1'b1 || busy1 !== 1'b0) begin errors++;
      $display("FAIL post_reset_idle: got ready=%b busy=%b expected 1/0", ready1, busy1); end
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL post_reset_ready0: got %b expected 1", ready0); end
  endtask

  task automatic test_basic();
    set_mem_default();
    run_cmd(1, 32'd30, 32'd2, 0, "basic");
    run_cmd(1, $urandom, $urandom, 0, "basic_rand");
  endtask

  task automatic test_hold();
    run_cmd(1, 32'd30, 32'd2, 3, "hold3");
    run_cmd(1, $urandom, $urandom, int'($urandom_range(1, 6)), "hold_rand");
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [31:0] sa, ta, sb, tb;
    sa = $urandom; ta = $urandom; sb = $urandom; tb = $urandom;
    q1.delete();
    cmd_swap_cycles = sa; cmd_swap_sets = ta; cmd_hold_cycles = 16'd0;
    cmd_valid1 = 1'b1;
    wait_accept(1, ok);
    if (!ok) begin cmd_valid1 = 1'b0; return; end
    // Second command is offered for the whole first sequence and must be ignored.
    cmd_swap_cycles = sb; cmd_swap_sets = tb; cmd_hold_cycles = 16'd0;
    check_seq(1, sa, ta, 0, 1000, "b2b_first");
    check_reads(1, "b2b_first");
    @(posedge clk); #1;
    cmd_valid1 = 1'b0;
    check_seq(1, sb, tb, 0, 1000, "b2b_second");
    check_reads(1, "b2b_second");
  endtask

  task automatic test_gap0();
    set_mem_default();
    run_cmd(0, 32'd30, 32'd2, 0, "gap0");
    run_cmd(0, $urandom, $urandom, int'($urandom_range(0, 3)), "gap0_rand");
  endtask

  task automatic test_reset_mid();
    bit ok;
    int en_seen;
    q1.delete();
    cmd_swap_cycles = 32'd77; cmd_swap_sets = 32'd5; cmd_hold_cycles = 16'd0;
    cmd_valid1 = 1'b1;
    wait_accept(1, ok);
    cmd_valid1 = 1'b0;
    if (!ok) return;
    check_seq(1, 32'd77, 32'd5, 0, 10, "rstmid_pre");
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (en1 !== 1'b0 || load1 !== 32'h0 || done1 !== 1'b0 || rd_en1 !== 1'b0 || busy1 !== 1'b0 || ready1 !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs: got en=%b load=%h done=%b rd_en=%b busy=%b ready=%b expected all 0",
               en1, load1, done1, rd_en1, busy1, ready1);
    end
    rst = 1'b0;
    q1.delete();
    @(posedge clk); #1;
    checks++;
    if (ready1 !== 1'b1 || busy1 !== 1'b0) begin errors++;
      $display("FAIL rstmid_ready: got ready=%b busy=%b expected 1/0", ready1, busy1); end
    en_seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (en1 !== 1'b0) en_seen++;
    end
    checks++;
    if (en_seen != 0) begin errors++; $display("FAIL rstmid_no_enable: got %0d enables expected 0", en_seen); end
    checks++;
    if (q1.size() != 0) begin errors++; $display("FAIL rstmid_no_reads: got %0d reads expected 0", q1.size()); end
    run_cmd(1, 32'd30, 32'd2, 0, "rstmid_replay");
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 2 * N; k++) mem1[k] = $urandom;
      run_cmd(1, $urandom, $urandom, int'($urandom_range(0, 4)), "random");
    end
  endtask

  task automatic test_max();
    set_mem_default();
    mem1[2 * N - 1] = 32'hFFFF_FFFF;
    mem0[2 * N - 1] = 16'hFFFF;
    run_cmd(1, 32'hFFFF_FFFF, $urandom, 0, "max");
    run_cmd(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "max_zext");
  endtask

  initial begin
    set_mem_default();
    test_reset();
    test_basic();
    test_hold();
    test_back_to_back();
    test_gap0();
    test_reset_mid();
    test_random();
    test_max();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
